// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers, evaluated at the widest supported width.
// Callers zero-extend into gray_word_t and truncate the result back to their own width.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Leading zero bits from zero-extension leave the low bits unaffected.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder for consumers of a synchronised Gray pointer.
// Latency: zero (pure combinational). No backpressure.
module gray2bin_dec
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(gray_word_t'(gray)));

endmodule

// File: rtl/gray_counter_updn.sv
// Up/down Gray counter with enable, parallel load and wrap pulse; bin and gray are registered together.
// Latency: one cycle from en/load to bin/gray/wrap; tc is combinational. No backpressure.
// GRAY_CNT_SAT_EN: saturate at the ends instead of wrapping; wrap then flags the first blocked step.
module gray_counter_updn
    import gray_pkg::*;
#(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(gray_word_t'(INIT)));

    if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_width_check
        $error("gray_counter_updn: WIDTH must be in 2..%0d", GRAY_MAX_WIDTH);
    end

    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] bin_nxt;
    logic             wrap_nxt;

    // tc doubles as the "next step crosses the end" flag for the current direction.
    assign tc       = up ? (bin == ALL_ONES) : (bin == '0);
    assign bin_step = up ? bin + WIDTH'(1) : bin - WIDTH'(1);

`ifdef GRAY_CNT_SAT_EN
    logic sat_hit;

    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            if (tc) begin
                wrap_nxt = !sat_hit;
            end else begin
                bin_nxt = bin_step;
            end
        end
    end

    // Remembers that the previous enabled step was blocked, so the pulse fires once per stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_hit <= 1'b0;
        end else if (load) begin
            sat_hit <= 1'b0;
        end else if (en) begin
            sat_hit <= tc;
        end
    end
`else
    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            bin_nxt  = bin_step;
            wrap_nxt = tc;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= INIT;
            gray <= INIT_GRAY;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= WIDTH'(bin2gray(gray_word_t'(bin_nxt)));
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter_updn.sv
// Directed bench for gray_counter_updn: 4-bit instance for sequences, 8-bit instance for a long random walk.
module tb_gray_counter_updn;

    logic       clk;
    logic       rst_n;

    logic       en, up, load;
    logic [3:0] load_val;
    logic [3:0] bin, gray;
    logic       wrap, tc;

    logic       en8, up8, load8;
    logic [7:0] load_val8;
    logic [7:0] bin8, gray8, dec8;
    logic       wrap8, tc8;

    int n_cmp = 0;
    int n_err = 0;

    // Gray code of 0..15, written out by hand.
    logic [3:0] g4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_counter_updn #(.WIDTH(4), .INIT(4'd0)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .bin(bin), .gray(gray), .wrap(wrap), .tc(tc)
    );

    gray_counter_updn #(.WIDTH(8), .INIT(8'hA5)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .up(up8), .load(load8),
        .load_val(load_val8), .bin(bin8), .gray(gray8), .wrap(wrap8), .tc(tc8)
    );

    gray2bin_dec #(.WIDTH(8)) dec (.gray(gray8), .bin(dec8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp8;
        logic [7:0] prev_g8;
        logic       bnd8;
        logic [3:0] expb;

        rst_n = 1'b1;
        en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
        en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_val8 = 8'd0;
        #2 rst_n = 1'b0;
        tick();
        tick();

        // Reset state for both instances
        chk("rst_bin", 32'(bin), 32'h0);
        chk("rst_gray", 32'(gray), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_tc_up", 32'(tc), 32'h0);
        chk("rst_bin8", 32'(bin8), 32'hA5);
        chk("rst_gray8", 32'(gray8), 32'hF7);
        chk("rst_wrap8", 32'(wrap8), 32'h0);

        rst_n = 1'b1;
        en = 1'b1;
        up = 1'b1;

`ifdef GRAY_CNT_SAT_EN
        // Saturating up: climb to 15, then stall with a single pulse
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("sat_up_bin", 32'(bin), 32'(k));
            chk("sat_up_gray", 32'(gray), 32'(g4[k]));
            chk("sat_up_wrap", 32'(wrap), 32'h0);
        end
        tick();
        chk("sat_hit_bin", 32'(bin), 32'hF);
        chk("sat_hit_gray", 32'(gray), 32'h8);
        chk("sat_hit_wrap", 32'(wrap), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sat_hold_bin", 32'(bin), 32'hF);
            chk("sat_hold_gray", 32'(gray), 32'h8);
            chk("sat_hold_wrap", 32'(wrap), 32'h0);
        end
        up = 1'b0;
        tick();
        chk("sat_leave_bin", 32'(bin), 32'hE);
        chk("sat_leave_gray", 32'(gray), 32'h9);
        chk("sat_leave_wrap", 32'(wrap), 32'h0);
        load = 1'b1;
        load_val = 4'd0;
        tick();
        load = 1'b0;
        tick();
        chk("sat_dn_bin", 32'(bin), 32'h0);
        chk("sat_dn_wrap", 32'(wrap), 32'h1);
        tick();
        chk("sat_dn_hold_bin", 32'(bin), 32'h0);
        chk("sat_dn_hold_wrap", 32'(wrap), 32'h0);
        en = 1'b0;
        up = 1'b1;
`else
        // Count up through the 15->0 wrap and one step beyond
        for (int k = 1; k <= 17; k++) begin
            tick();
            expb = 4'(k);
            chk("up_bin", 32'(bin), 32'(expb));
            chk("up_gray", 32'(gray), 32'(g4[expb]));
            chk("up_wrap", 32'(wrap), (k == 16) ? 32'h1 : 32'h0);
            chk("up_tc", 32'(tc), (expb == 4'hF) ? 32'h1 : 32'h0);
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("up2_bin", 32'(bin), 32'(k));
        end
        chk("at5_gray", 32'(gray), 32'h7);

        // Direction change takes effect on the very next edge
        up = 1'b0;
        #1;
        chk("dn_tc_at5", 32'(tc), 32'h0);
        tick();
        chk("dn_bin4", 32'(bin), 32'h4);
        chk("dn_gray4", 32'(gray), 32'h6);
        chk("dn_wrap4", 32'(wrap), 32'h0);
        for (int k = 3; k >= 0; k--) begin
            tick();
            chk("dn_bin", 32'(bin), 32'(k));
            chk("dn_gray", 32'(gray), 32'(g4[k]));
            chk("dn_wrap", 32'(wrap), 32'h0);
        end
        chk("dn_tc_at0", 32'(tc), 32'h1);
        tick();
        chk("dn_wrap_bin", 32'(bin), 32'hF);
        chk("dn_wrap_gray", 32'(gray), 32'h8);
        chk("dn_wrap_pulse", 32'(wrap), 32'h1);
        en = 1'b0;
        tick();
        chk("idle_bin", 32'(bin), 32'hF);
        chk("idle_wrap", 32'(wrap), 32'h0);
        up = 1'b1;
`endif

        // Load wins over count
        load = 1'b1;
        en = 1'b1;
        load_val = 4'b1010;
        tick();
        chk("load_bin", 32'(bin), 32'hA);
        chk("load_gray", 32'(gray), 32'hF);
        chk("load_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_bin", 32'(bin), 32'hA);
            chk("hold_gray", 32'(gray), 32'hF);
            chk("hold_wrap", 32'(wrap), 32'h0);
        end

        // Load at the terminal count must not raise wrap
        load = 1'b1;
        load_val = 4'hF;
        tick();
        en = 1'b1;
        load_val = 4'h3;
        #1;
        chk("ld_tc", 32'(tc), 32'h1);
        tick();
        chk("ld_tc_bin", 32'(bin), 32'h3);
        chk("ld_tc_gray", 32'(gray), 32'h2);
        chk("ld_tc_wrap", 32'(wrap), 32'h0);

        // Asynchronous reset between clock edges
        load_val = 4'h9;
        en = 1'b0;
        tick();
        load = 1'b0;
        chk("pre_rst_bin", 32'(bin), 32'h9);
        chk("pre_rst_gray", 32'(gray), 32'hD);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bin", 32'(bin), 32'h0);
        chk("arst_gray", 32'(gray), 32'h0);
        chk("arst_wrap", 32'(wrap), 32'h0);
        chk("arst_bin8", 32'(bin8), 32'hA5);
        tick();
        rst_n = 1'b1;

        // 8-bit random walk, biased up then down so it crosses both ends
        exp8 = 8'hA5;
        for (int i = 0; i < 2000; i++) begin
            en8 = 1'($urandom_range(0, 1));
            up8 = ($urandom_range(0, 9) < 9) ^ (i >= 1000);
            #1;
            bnd8 = up8 ? (exp8 == 8'hFF) : (exp8 == 8'h00);
            chk("rnd_tc", 32'(tc8), 32'(bnd8));
            prev_g8 = gray8;
            tick();
`ifdef GRAY_CNT_SAT_EN
            if (en8 && !bnd8) exp8 = up8 ? exp8 + 8'd1 : exp8 - 8'd1;
`else
            if (en8) exp8 = up8 ? exp8 + 8'd1 : exp8 - 8'd1;
            chk("rnd_wrap", 32'(wrap8), 32'(en8 && bnd8));
`endif
            chk("rnd_bin", 32'(bin8), 32'(exp8));
            chk("rnd_onebit", ($countones(gray8 ^ prev_g8) <= 1) ? 32'h1 : 32'h0, 32'h1);
            chk("rnd_dec", 32'(dec8), 32'(exp8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
